// File: rtl/fc_pkg.sv
// fc_pkg: shared FC back-end types, defaults and the sram f byte-lane mapping
package fc_pkg;

    localparam int CLASS_NUM_DEF  = 10;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int LANES_DEF      = 4;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, RESULT} state_t;

    // Lane 0 is the most significant byte, matching bytemask 1000/0100/0010/0001
    function automatic logic [DATA_WIDTH_DEF-1:0] lane_sel(
        input logic [DATA_WIDTH_DEF*LANES_DEF-1:0] word,
        input logic [1:0]                           lane
    );
        return word[DATA_WIDTH_DEF*(LANES_DEF-1-int'(lane)) +: DATA_WIDTH_DEF];
    endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// fc_argmax_tracker: running signed maximum and its index; ties keep the earlier index
module fc_argmax_tracker #(
    parameter int DATA_WIDTH = 8
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         update,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic [3:0]                   din_idx,
    output logic signed [DATA_WIDTH-1:0] max_val,
    output logic [3:0]                   max_idx
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (load || (update && din > max_val)) begin
            max_val <= din;
            max_idx <= din_idx;
        end
    end

endmodule

// File: rtl/fc_result_reader.sv
// fc_result_reader: sweeps the FC2 scores out of sram f, streams them and reports the argmax
module fc_result_reader
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH             = DATA_WIDTH_DEF,
    parameter int DATA_NUM_PER_SRAM_ADDR = LANES_DEF,
    parameter int CLASS_NUM              = CLASS_NUM_DEF,
    parameter int ADDR_WIDTH             = 10
)(
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         fc2_done,
    output logic [ADDR_WIDTH-1:0]                        sram_raddr_f,
    input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_f,
    output logic                                         score_valid,
    input  logic                                         score_ready,
    output logic signed [DATA_WIDTH-1:0]                 score_data,
    output logic [3:0]                                   score_idx,
    output logic                                         score_last,
    output logic                                         result_valid,
    output logic [3:0]                                   result_class,
    output logic signed [DATA_WIDTH-1:0]                 result_max,
    output logic                                         busy
);

    localparam logic [3:0] LAST_IDX = 4'(CLASS_NUM - 1);

    state_t                       state;
    logic                         pend;
    logic [3:0]                   idx;
    logic signed [DATA_WIDTH-1:0] lane_data;
    logic signed [DATA_WIDTH-1:0] trk_max;
    logic [3:0]                   trk_cls;

    assign lane_data = lane_sel(sram_rdata_f, idx[1:0]);

    fc_argmax_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .load    (state == WAIT && idx == 4'd0),
        .update  (state == WAIT),
        .din     (lane_data),
        .din_idx (idx),
        .max_val (trk_max),
        .max_idx (trk_cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pend         <= 1'b0;
            idx          <= '0;
            sram_raddr_f <= '0;
            score_valid  <= 1'b0;
            score_data   <= '0;
            score_idx    <= '0;
            score_last   <= 1'b0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_max   <= '0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (fc2_done)
                pend <= 1'b1;
            case (state)
                IDLE: begin
                    busy <= fc2_done || pend;
                    if (fc2_done || pend) begin
                        state        <= FETCH;
                        idx          <= '0;
                        sram_raddr_f <= '0;
                        pend         <= 1'b0;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    state       <= SEND;
                    score_valid <= 1'b1;
                    score_data  <= lane_data;
                    score_idx   <= idx;
                    score_last  <= idx == LAST_IDX;
                end
                SEND: if (score_ready) begin
                    score_valid <= 1'b0;
                    score_last  <= 1'b0;
                    if (idx == LAST_IDX) begin
                        state        <= RESULT;
                        result_valid <= 1'b1;
                        result_class <= trk_cls;
                        result_max   <= trk_max;
                    end else begin
                        state        <= FETCH;
                        idx          <= idx + 4'd1;
                        sram_raddr_f <= sram_raddr_f + 1'b1;
                    end
                end
                RESULT: begin
                    state <= IDLE;
                    busy  <= pend || fc2_done;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_result_reader.sv
// tb_fc_result_reader: scoreboard bench for the sram f score reader
module tb_fc_result_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fc2_done = 1'b0;
    logic        score_ready = 1'b1;
    logic [9:0]  sram_raddr_f;
    logic [31:0] sram_rdata_f = '0;
    logic        score_valid, score_last, result_valid, busy;
    logic signed [7:0] score_data, result_max;
    logic [3:0]  score_idx, result_class;

    fc_result_reader dut (
        .clk(clk), .rst(rst), .fc2_done(fc2_done),
        .sram_raddr_f(sram_raddr_f), .sram_rdata_f(sram_rdata_f),
        .score_valid(score_valid), .score_ready(score_ready),
        .score_data(score_data), .score_idx(score_idx), .score_last(score_last),
        .result_valid(result_valid), .result_class(result_class),
        .result_max(result_max), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f[3:0]];

    typedef struct {int data; int idx; int last;} score_t;
    typedef struct {int cls; int mx;} res_t;
    score_t sq[$];
    res_t   rq[$];
    score_t se;
    res_t   re;
    int scores[10];
    int tests = 0, fails = 0;
    int cyc = 0, e0cyc = 0, res_cnt = 0, busy_low = 0, stall_cnt = 0;
    int res_cycs[$];
    int s0_cycs[$];
    bit stall_en = 0, track_busy = 0, prev_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            score_ready = 1'b1;
            if (stall_en && score_valid && score_idx == 4'd4 && stall_cnt < 5 && sq.size() > 0) begin
                score_ready = 1'b0;
                stall_cnt++;
                check("stall_data", int'(score_data), sq[0].data);
                check("stall_idx", int'(score_idx), 4);
                check("stall_addr", int'(sram_raddr_f), 4);
            end
            if (score_valid && !prev_valid && score_idx == 4'd0)
                s0_cycs.push_back(cyc);
            prev_valid = score_valid;
            if (score_valid && score_ready) begin
                if (sq.size() == 0) check("sb_score_empty", 1, 0);
                else begin
                    se = sq.pop_front();
                    check("score_data", int'(score_data), se.data);
                    check("score_idx", int'(score_idx), se.idx);
                    check("score_last", int'(score_last), se.last);
                end
            end
            if (result_valid) begin
                res_cnt++;
                res_cycs.push_back(cyc);
                if (rq.size() == 0) check("sb_result_empty", 1, 0);
                else begin
                    re = rq.pop_front();
                    check("result_class", int'(result_class), re.cls);
                    check("result_max", int'(result_max), re.mx);
                end
            end
            if (track_busy && !busy) busy_low++;
        end
    end

    task automatic load_mem();
        logic [31:0] w;
        for (int k = 0; k < 10; k++) begin
            w = $urandom;
            w[8*(3-(k%4)) +: 8] = 8'(scores[k]);
            mem[k] = w;
        end
    endtask

    task automatic push_sweep();
        score_t s;
        res_t r;
        r.cls = 0;
        r.mx = scores[0];
        for (int k = 0; k < 10; k++) begin
            s.data = scores[k];
            s.idx = k;
            s.last = (k == 9);
            sq.push_back(s);
            if (scores[k] > r.mx) begin
                r.mx = scores[k];
                r.cls = k;
            end
        end
        rq.push_back(r);
    endtask

    task automatic pulse();
        fc2_done = 1'b1;
        @(negedge clk);
        fc2_done = 1'b0;
        e0cyc = cyc;
    endtask

    task automatic wait_res(input int n);
        for (int i = 0; i < 400 && res_cnt < n; i++) @(negedge clk);
        check("result_timeout", int'(res_cnt >= n), 1);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    endtask

    task automatic wait_idx(input int n);
        int i;
        for (i = 0; i < 100 && !(score_valid && score_idx == 4'(n)); i++) @(negedge clk);
        check("idx_timeout", int'(i < 100), 1);
    endtask

    task automatic sweep(input int n);
        load_mem();
        push_sweep();
        @(negedge clk);
        pulse();
        wait_res(n);
    endtask

    initial begin
        int rc;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(score_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rvalid", int'(result_valid), 0);
        check("rst_addr", int'(sram_raddr_f), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 10; k++) scores[k] = 10*k - 40;
        load_mem();
        push_sweep();
        @(negedge clk);
        pulse();
        check("e0_busy", int'(busy), 1);
        check("e0_addr", int'(sram_raddr_f), 0);
        wait_res(1);
        check("sweep_cycles", res_cycs[0] - e0cyc + 1, 31);
        check("idle_busy", int'(busy), 0);
        check("idle_addr", int'(sram_raddr_f), 9);

        for (int k = 0; k < 10; k++) scores[k] = 0;
        scores[2] = 77;
        scores[6] = 77;
        sweep(2);

        for (int k = 0; k < 10; k++) scores[k] = -50 - k;
        scores[0] = -128;
        scores[8] = -3;
        sweep(3);

        for (int k = 0; k < 10; k++) scores[k] = 7*k - 20;
        stall_en = 1;
        stall_cnt = 0;
        sweep(4);
        stall_en = 0;
        check("stall_cycles", stall_cnt, 5);

        for (int k = 0; k < 10; k++) scores[k] = int'($urandom_range(0, 255)) - 128;
        res_cycs.delete();
        s0_cycs.delete();
        load_mem();
        push_sweep();
        @(negedge clk);
        busy_low = 0;
        pulse();
        track_busy = 1;
        wait_idx(3);
        push_sweep();
        pulse();
        wait_idx(5);
        pulse();
        wait_res(6);
        track_busy = 0;
        repeat (30) @(negedge clk);
        check("pend_results", res_cnt, 6);
        check("pend_busy_low", busy_low, 0);
        check("pend_restart", (s0_cycs.size() > 1 && res_cycs.size() > 0) ? s0_cycs[1] - res_cycs[0] : -1, 4);

        for (int k = 0; k < 10; k++) scores[k] = 3*k;
        load_mem();
        push_sweep();
        @(negedge clk);
        pulse();
        wait_idx(5);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", int'(score_valid), 0);
        check("arst_data", int'(score_data), 0);
        check("arst_idx", int'(score_idx), 0);
        check("arst_last", int'(score_last), 0);
        check("arst_rvalid", int'(result_valid), 0);
        check("arst_rclass", int'(result_class), 0);
        check("arst_rmax", int'(result_max), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_addr", int'(sram_raddr_f), 0);
        sq.delete();
        rq.delete();
        rc = res_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_no_result", res_cnt, rc);
        for (int k = 0; k < 10; k++) scores[k] = 100 - 9*k;
        sweep(rc + 1);
        check("sb_drained", sq.size() + rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
